mem_stage: RTL
==============

Name: mem_stage

Overview:
MEM pipeline stage plus MEM/WB pipeline register of the 5-stage CPU. It takes the EX/MEM bundle and runs loads and stores on a variable-latency data-memory port using a req/ready handshake. It formats load data for byte, half and word accesses, with sign or zero extension, and stalls the upstream pipeline while an access is outstanding. Its registered MEM/WB outputs feed the write-back mux and the ID-stage forwarding/regfile write path directly.

Parameters:
TIMEOUT_CYCLES, 255, maximum BUSY cycles without dmem_ready before the access is aborted
REG_ADDR_W, 5, register-file address width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
in_valid  in  1  EX/MEM slot holds a real instruction (0 = bubble)
EXMEM_ALUout  in  32  ALU result / memory byte address
EXMEM_StoreData  in  32  store source register value
EXMEM_MemRead  in  1  load
EXMEM_MemWrite  in  1  store
EXMEM_MemSize  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
EXMEM_MemSigned  in  1  sign-extend load result
EXMEM_MemtoReg  in  1  passed through
EXMEM_RegWrite  in  1  passed through
EXMEM_WriteRegAddr  in  REG_ADDR_W  passed through
mem_stall  out  1  hold PC/IF/ID/EX and EX/MEM registers this cycle
dmem_req  out  1  memory request valid
dmem_we  out  1  1 = write
dmem_addr  out  32  word address (byte address with [1:0] = 0)
dmem_be  out  4  byte enables, bit i = byte lane i (little-endian)
dmem_wdata  out  32  lane-aligned store data
dmem_rdata  in  32  read data, valid when dmem_ready=1
dmem_ready  in  1  access complete this cycle
MEMWB_ALUout  out  32  registered
MEMWB_MEMout  out  32  registered, formatted load data
MEMWB_MemtoReg  out  1  registered
MEMWB_RegWrite  out  1  registered
MEMWB_WriteRegAddr  out  REG_ADDR_W  registered
bus_err  out  1  one-cycle pulse on timeout abort
misalign_exc  out  1  one-cycle pulse on misaligned access (feature only)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timeout counter 0. dmem_req drops asynchronously, even mid-access; the in-flight access is abandoned.
- mem_op = in_valid & (MemRead | MemWrite).
- FSM states IDLE and BUSY.
- IDLE with no mem_op: MEM/WB loads the bundle next edge, RegWrite gated by in_valid, MEMout = 0. mem_stall = 0. Latency 1.
- IDLE with mem_op:
  - mem_stall = 1 combinationally.
  - Register the request fields (addr, be, wdata, we, size, signed, lane) and go to BUSY.
  - MEM/WB loads a bubble: RegWrite = 0, other fields 0.
- BUSY:
  - dmem_req = 1; request fields are held stable until ready.
  - mem_stall = ~dmem_ready.
  - While waiting, MEM/WB loads a bubble each cycle.
  - On dmem_ready: MEM/WB loads the bundle, with MEMout = formatted rdata for loads and 0 for stores. Go to IDLE.
  - Minimum memory-op latency is 2 cycles (ready in the first BUSY cycle).
- Store lanes:
  - Byte: be = 1 << addr[1:0], wdata = {4{data[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011, wdata = {2{data[15:0]}}.
  - Word: be = 1111.
- Load format:
  - Byte: select rdata lane addr[1:0].
  - Half: select rdata[31:16] if addr[1], else rdata[15:0].
  - Extend to 32 bits with sign if MemSigned, else zero.
  - Loads drive be = 1111.
- Timeout counter:
  - Clears on entry to BUSY and increments each BUSY cycle without ready.
  - When it reaches TIMEOUT_CYCLES-1 with no ready: next edge drop req, pulse bus_err, write a bubble to MEM/WB, return to IDLE.
  - mem_stall deasserts in that final cycle so the instruction retires as a no-op.
- If dmem_ready arrives in the same cycle as the timeout, ready wins and there is no bus_err.
- dmem_ready while in IDLE is ignored.
- Misalignment without the feature: half ignores addr[0], word ignores addr[1:0].

Optional Feature:
MEM_MISALIGN_EXC_EN:
- When defined: a mem_op in IDLE with (half & addr[0]) or (word & addr[1:0] != 0) issues no memory request. Same cycle: mem_stall = 0, misalign_exc pulses for 1 cycle, and MEM/WB loads a bubble.
- When undefined: misalign_exc is tied 0 and the low-bit masking above applies.

Decomposition:
- Shared package cpu_pkg:
  - MemSize encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
  - FSM state encodings (ST_IDLE, ST_BUSY).
  - Default TIMEOUT_CYCLES.
- One natural combinational sub-module, load_formatter: inputs rdata, addr[1:0], size, signed; output 32-bit extended data. It is reused later by the D-cache refill path.

Test Plan:
- ALU op, no memory access (ALUout=0x1234, RegWrite=1, rd=5) -> next cycle MEMWB_ALUout=0x1234, RegWrite=1, rd=5; mem_stall never high.
- lw addr 0x100, dmem_ready 3 cycles after req, rdata=0xDEADBEEF -> mem_stall high 3 cycles; then MEMWB_MEMout=0xDEADBEEF, RegWrite=1; bubbles (RegWrite=0) in between.
- lb signed at 0x103 with rdata=0x80xxxxxx -> MEMout=0xFFFFFF80; the same access as lbu -> 0x00000080; lh signed at 0x102 with rdata=0x8001xxxx -> MEMout=0xFFFF8001.
- sb data=0x000000AB at 0x201 -> dmem_addr=0x200, be=0010, wdata=0xABABABAB, we=1; sh at 0x202 -> be=1100.
- Memory never ready, TIMEOUT_CYCLES=4 -> req drops after 4 BUSY cycles, bus_err pulses once, MEM/WB RegWrite=0, FSM back to IDLE. A separate run asserts rst_n low mid-BUSY -> dmem_req=0 immediately and all outputs 0.
- With MEM_MISALIGN_EXC_EN, lw at 0x102 -> no dmem_req, misalign_exc=1 for 1 cycle, bubble written. Without the macro -> dmem_addr=0x100, normal load.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU encodings: memory access sizes, MEM-stage FSM states and
// the default data-memory timeout.
package cpu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ready port: the MEM stage is the master, the memory the slave.
interface mem_stage_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (output req, we, addr, be, wdata, input rdata, ready);
    modport slave  (input req, we, addr, be, wdata, output rdata, ready);

endinterface

// File: rtl/load_formatter.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module load_formatter
    import cpu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        case (size)
            SZ_BYTE: data = {{24{is_signed & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{is_signed & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage + MEM/WB register driving a variable-latency req/ready data memory.
// Define MEM_MISALIGN_EXC_EN to trap misaligned half/word accesses instead of masking.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int REG_ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [31:0]           EXMEM_ALUout,
    input  logic [31:0]           EXMEM_StoreData,
    input  logic                  EXMEM_MemRead,
    input  logic                  EXMEM_MemWrite,
    input  logic [1:0]            EXMEM_MemSize,
    input  logic                  EXMEM_MemSigned,
    input  logic                  EXMEM_MemtoReg,
    input  logic                  EXMEM_RegWrite,
    input  logic [REG_ADDR_W-1:0] EXMEM_WriteRegAddr,
    output logic                  mem_stall,
    mem_stage_if.master           dmem,
    output logic [31:0]           MEMWB_ALUout,
    output logic [31:0]           MEMWB_MEMout,
    output logic                  MEMWB_MemtoReg,
    output logic                  MEMWB_RegWrite,
    output logic [REG_ADDR_W-1:0] MEMWB_WriteRegAddr,
    output logic                  bus_err,
    output logic                  misalign_exc
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addr_r;
    logic [31:0]      wdata_r;
    logic [3:0]       be_r;
    logic             we_r;
    logic [1:0]       size_r;
    logic [1:0]       lane_r;
    logic             sign_r;

    logic             mem_op;
    logic             misalign;
    logic             busy;
    logic             timeout_hit;
    logic [3:0]       be_n;
    logic [31:0]      wdata_n;
    logic [31:0]      load_data;

    assign mem_op      = in_valid & (EXMEM_MemRead | EXMEM_MemWrite);
    assign busy        = (state == ST_BUSY);
    assign timeout_hit = busy & ~dmem.ready & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Ready wins over timeout; on timeout the held instruction retires as a no-op.
    assign mem_stall = busy ? (~dmem.ready & ~timeout_hit) : (mem_op & ~misalign);

    assign dmem.req   = busy;
    assign dmem.we    = we_r;
    assign dmem.addr  = addr_r;
    assign dmem.be    = be_r;
    assign dmem.wdata = wdata_r;

`ifdef MEM_MISALIGN_EXC_EN
    logic misalign_r;

    assign misalign = mem_op & ((EXMEM_MemSize == SZ_HALF) ? EXMEM_ALUout[0]
                              : (EXMEM_MemSize[1] & (EXMEM_ALUout[1:0] != 2'b00)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_r <= 1'b0;
        else        misalign_r <= ~busy & misalign;
    end

    assign misalign_exc = misalign_r;
`else
    assign misalign     = 1'b0;
    assign misalign_exc = 1'b0;
`endif

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = EXMEM_StoreData;
        if (EXMEM_MemWrite) begin
            case (EXMEM_MemSize)
                SZ_BYTE: begin
                    be_n    = 4'b0001 << EXMEM_ALUout[1:0];
                    wdata_n = {4{EXMEM_StoreData[7:0]}};
                end
                SZ_HALF: begin
                    be_n    = EXMEM_ALUout[1] ? 4'b1100 : 4'b0011;
                    wdata_n = {2{EXMEM_StoreData[15:0]}};
                end
                default: ;
            endcase
        end
    end

    load_formatter u_fmt (
        .rdata     (dmem.rdata),
        .lane      (lane_r),
        .size      (size_r),
        .is_signed (sign_r),
        .data      (load_data)
    );

    // MEM/WB defaults to a bubble; only a completing instruction overwrites it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            addr_r             <= '0;
            wdata_r            <= '0;
            be_r               <= '0;
            we_r               <= 1'b0;
            size_r             <= '0;
            lane_r             <= '0;
            sign_r             <= 1'b0;
            MEMWB_ALUout       <= '0;
            MEMWB_MEMout       <= '0;
            MEMWB_MemtoReg     <= 1'b0;
            MEMWB_RegWrite     <= 1'b0;
            MEMWB_WriteRegAddr <= '0;
            bus_err            <= 1'b0;
        end else begin
            MEMWB_ALUout       <= '0;
            MEMWB_MEMout       <= '0;
            MEMWB_MemtoReg     <= 1'b0;
            MEMWB_RegWrite     <= 1'b0;
            MEMWB_WriteRegAddr <= '0;
            bus_err            <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_op && !misalign) begin
                        state   <= ST_BUSY;
                        cnt     <= '0;
                        addr_r  <= {EXMEM_ALUout[31:2], 2'b00};
                        be_r    <= be_n;
                        wdata_r <= wdata_n;
                        we_r    <= EXMEM_MemWrite;
                        size_r  <= EXMEM_MemSize;
                        lane_r  <= EXMEM_ALUout[1:0];
                        sign_r  <= EXMEM_MemSigned;
                    end else if (!mem_op) begin
                        MEMWB_ALUout       <= EXMEM_ALUout;
                        MEMWB_MemtoReg     <= EXMEM_MemtoReg;
                        MEMWB_RegWrite     <= EXMEM_RegWrite & in_valid;
                        MEMWB_WriteRegAddr <= EXMEM_WriteRegAddr;
                    end
                end
                ST_BUSY: begin
                    if (dmem.ready) begin
                        state              <= ST_IDLE;
                        MEMWB_ALUout       <= EXMEM_ALUout;
                        MEMWB_MEMout       <= we_r ? 32'd0 : load_data;
                        MEMWB_MemtoReg     <= EXMEM_MemtoReg;
                        MEMWB_RegWrite     <= EXMEM_RegWrite & in_valid;
                        MEMWB_WriteRegAddr <= EXMEM_WriteRegAddr;
                    end else if (timeout_hit) begin
                        state   <= ST_IDLE;
                        bus_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
